// File: rtl/mips_fetch_pkg.sv
// Types and constants shared by the instruction fetch stage and the
// single-cycle MIPS execute core it feeds.
package mips_fetch_pkg;

  localparam int FETCH_DEPTH = 16;
  localparam int FETCH_AW    = 4;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Primary opcodes (instr[31:26]) understood by the execute core
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/mips_instr_fetch_mem.sv
// Program RAM: one synchronous write port, one synchronous read port with
// a single cycle of latency and read-old-data on an address collision.
module instr_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch so it maps onto block RAM; the
  // non-blocking read and write in one process give read-before-write.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/mips_instr_fetch.sv
// Fetch sequencer: walks the program RAM from address 0 and hands one
// instruction at a time to the execute core, in free-run or single-step.
module mips_instr_fetch #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [31:0] HALT_WORD = mips_fetch_pkg::HALT_WORD
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          run_mode,
  input  logic          step,
  input  logic          hold,
  input  logic          restart,
  output logic [31:0]   instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  import mips_fetch_pkg::*;

  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          step_q;
  logic          step_rise;
  logic [31:0]   rd_data;
  logic          rd_is_halt;
  logic          at_last;

  assign step_rise  = step & ~step_q;
  assign rd_is_halt = (rd_data == HALT_WORD);
  assign at_last    = (pc_q == LAST_PC);

  // Addressing with the next pc lets the RAM word for the following fetch
  // be ready in READ even when pc advances on the same edge.
  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (load_en),
    .wr_addr_i (load_addr),
    .wr_data_i (load_data),
    .rd_addr_i (pc_d),
    .rd_data_o (rd_data)
  );

  // NOTE: sequential state is assigned with <= only, so every register
  // samples the values that were settled before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      step_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      step_q  <= step;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((run_mode | step_rise) & ~load_en) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = rd_is_halt ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!hold) begin
          if (at_last) begin
            state_d = ST_HALT;
          end else begin
            state_d = run_mode ? ST_READ : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (state_q == ST_ISSUE && !hold && !at_last) begin
      pc_d = pc_q + AW'(1);
    end
    if (state_q == ST_READ && !rd_is_halt) begin
      instr_d = rd_data;
    end
    if (restart) begin
      pc_d    = '0;
      instr_d = instr_q;
    end
  end

  always_comb begin
    instr_valid = (state_q == ST_ISSUE);
    halted      = (state_q == ST_HALT);
  end

  assign instruction = instr_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Bench for the fetch sequencer: vector table, directed corner sequences
// and random programs checked against a transaction-level program model.
module tb_mips_instr_fetch;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] P0    = 32'h2008_0005;
  localparam logic [31:0] P1    = 32'h0108_4020;
  localparam logic [31:0] P_LUI = 32'h3C01_ABCD;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          run_mode, step, hold, restart;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          halted;

  int total = 0;
  int bad   = 0;

  mips_instr_fetch #(.DEPTH(DEPTH), .AW(AW), .HALT_WORD(HALTW)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .run_mode    (run_mode),
    .step        (step),
    .hold        (hold),
    .restart     (restart),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        run;
    logic        stp;
    logic        hld;
    logic        rst;
    int          reps;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [3:0]  exp_pc;
    logic        exp_halted;
  } vec_t;

  typedef struct {
    logic [3:0]  pc;
    logic [31:0] instr;
  } issue_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs set before the rising edge, outputs read at the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic do_restart();
    run_mode = 1'b0;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
  endtask

  task automatic wait_valid_at(input logic [3:0] p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid && pc == p) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (halted) begin
        ok = 1'b1;
        return;
      end
      if (instr_valid) check("halt_word_issued", {31'b0, instruction == HALTW}, 32'd0);
      tick();
    end
  endtask

  // Expected issue list of a free-run program, derived from the fetch rules.
  function automatic void model_run(input logic [31:0] prog[DEPTH],
                                    output issue_t exp_q[$], output logic [3:0] final_pc);
    exp_q = {};
    final_pc = 4'(DEPTH - 1);
    for (int a = 0; a < DEPTH; a++) begin
      if (prog[a] == HALTW) begin
        final_pc = 4'(a);
        return;
      end
      exp_q.push_back('{pc: 4'(a), instr: prog[a]});
    end
  endfunction

  initial begin
    vec_t        vecs[$];
    bit          ok;
    int          cnt;
    logic [31:0] prog[DEPTH];
    issue_t      exp_q[$];
    logic [3:0]  final_pc;

    // Reset with step and run_mode high; program loaded while in reset.
    reset = 1'b1; run_mode = 1'b1; step = 1'b1; hold = 1'b0; restart = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clock);
    load_word(4'd0, P0);
    load_word(4'd1, P1);
    load_word(4'd2, HALTW);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_pc", pc, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_instr", instruction, 0);
    end
    reset = 1'b0;
    tick();
    check("rst_first_valid_early", instr_valid, 0);
    tick();
    check("rst_first_valid", instr_valid, 1);
    check("rst_first_instr", instruction, P0);
    wait_halted(20, ok);
    check("rst_run_halts", ok, 1);
    check("rst_halt_pc", pc, 2);
    step = 1'b0;

    // Free-run timing and single-step behaviour, cycle by cycle.
    vecs.push_back('{0, 0, 0, 1, 1, 0, 32'h0, 4'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 0, 32'h0, 4'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 1, P0,    4'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 0, 32'h0, 4'd1, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 1, P1,    4'd1, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 0, 32'h0, 4'd2, 0});
    vecs.push_back('{1, 0, 0, 0, 3, 0, 32'h0, 4'd2, 1});
    vecs.push_back('{0, 0, 0, 1, 1, 0, 32'h0, 4'd0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 32'h0, 4'd0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 1, P0,    4'd0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 32'h0, 4'd1, 0});
    vecs.push_back('{0, 1, 0, 0, 10, 0, 32'h0, 4'd1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 32'h0, 4'd1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 32'h0, 4'd1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 1, P1,    4'd1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 32'h0, 4'd2, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 32'h0, 4'd2, 0});
    vecs.push_back('{0, 0, 0, 0, 2, 0, 32'h0, 4'd2, 1});
    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        run_mode = vecs[v].run; step = vecs[v].stp;
        hold = vecs[v].hld; restart = vecs[v].rst;
        tick();
        check($sformatf("vec%0d_valid", v), instr_valid, vecs[v].exp_valid);
        check($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
        check($sformatf("vec%0d_halted", v), halted, vecs[v].exp_halted);
        if (vecs[v].exp_valid) check($sformatf("vec%0d_instr", v), instruction, vecs[v].exp_instr);
      end
    end
    restart = 1'b0; step = 1'b0;

    // Hold for three cycles while mem[1] is being issued.
    do_restart();
    run_mode = 1'b1;
    wait_valid_at(4'd1, 20, ok);
    check("hold_reach_issue", ok, 1);
    cnt = 1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (instr_valid) cnt++;
      check("hold_instr", instruction, P1);
      check("hold_pc", pc, 1);
    end
    hold = 1'b0;
    tick();
    check("hold_valid_cycles", cnt, 4);
    check("hold_release_valid", instr_valid, 0);
    check("hold_release_pc", pc, 2);
    wait_halted(20, ok);
    check("hold_then_halt", ok, 1);

    // End of memory: all nops, no wrap.
    run_mode = 1'b0;
    for (int a = 0; a < DEPTH; a++) load_word(4'(a), 32'h0);
    do_restart();
    run_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      if (instr_valid) begin
        check("eom_issue_pc", pc, cnt);
        cnt++;
      end
      tick();
    end
    check("eom_issue_count", cnt, DEPTH);
    check("eom_halted", halted, 1);
    check("eom_pc", pc, DEPTH - 1);
    repeat (3) tick();
    check("eom_pc_stays", pc, DEPTH - 1);
    check("eom_still_halted", halted, 1);

    // Restart mid-run with a same-cycle program write.
    run_mode = 1'b0;
    load_word(4'd0, P0);
    load_word(4'd1, P1);
    load_word(4'd2, HALTW);
    do_restart();
    run_mode = 1'b1;
    wait_valid_at(4'd1, 20, ok);
    check("rsm_reach_issue", ok, 1);
    restart = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = P_LUI;
    tick();
    restart = 1'b0; load_en = 1'b0;
    check("rsm_pc", pc, 0);
    check("rsm_valid", instr_valid, 0);
    check("rsm_halted", halted, 0);
    tick();
    check("rsm_read_valid", instr_valid, 0);
    tick();
    check("rsm_new_valid", instr_valid, 1);
    check("rsm_new_instr", instruction, P_LUI);
    check("rsm_new_pc", pc, 0);

    // Random programs, free-run with random hold, against the program model.
    for (int it = 0; it < 8; it++) begin
      run_mode = 1'b0; hold = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        prog[a] = (it != 0 && $urandom_range(0, 5) == 0) ? HALTW : $urandom;
        load_word(4'(a), prog[a]);
      end
      model_run(prog, exp_q, final_pc);
      do_restart();
      run_mode = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        if (halted) begin
          ok = 1'b1;
        end else begin
          if (instr_valid) begin
            check("rnd_issue_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              check("rnd_pc", pc, exp_q[0].pc);
              check("rnd_instr", instruction, exp_q[0].instr);
            end
          end
          hold = ($urandom_range(0, 2) == 0);
          if (instr_valid && !hold && exp_q.size() != 0) void'(exp_q.pop_front());
          tick();
        end
      end
      hold = 1'b0;
      check("rnd_halted", ok, 1);
      check("rnd_all_issued", exp_q.size(), 0);
      check("rnd_final_pc", pc, final_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
